// File: rtl/vram_pkg.sv
// Shared types and constants for the Pico VRAM write controller.
// Holds coordinate/colour widths, FSM enums and the {row, col} address packer.
package vram_pkg;
  localparam int COORD_W = 7;
  localparam int COLOR_W = 4;
  localparam int VRAM_AW = 2 * COORD_W;

  typedef enum logic {ST_IDLE, ST_FILL} state_t;
  typedef enum logic {TURN_FILL, TURN_HOST} turn_t;

  function automatic logic [VRAM_AW-1:0] pack_addr(
    input logic [COORD_W-1:0] row,
    input logic [COORD_W-1:0] col
  );
    return {row, col};
  endfunction
endpackage

// File: rtl/vram_write_ctrl_if.sv
// Host pixel-write request channel (valid/ready).
// master: req_valid/req_x/req_y/req_color out, req_ready in; slave mirrors it.
interface vram_write_ctrl_if;
  import vram_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [COLOR_W-1:0] req_color;

  modport master (
    output req_valid, req_x, req_y, req_color,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color,
    output req_ready
  );
endinterface

// File: rtl/vram_fill_walker.sv
// Rectangle raster walker: latches the rectangle on load, advances on step.
// Ports: clk, rst, load, step, x0/y0/x1/y1 in; cur_x, cur_y, last out.
module vram_fill_walker
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               last
);
  logic [COORD_W-1:0] rx0, rx1, ry1;
  logic [COORD_W-1:0] cx, cy;

  assign cur_x = cx;
  assign cur_y = cy;
  assign last  = (cx == rx1) && (cy == ry1);

  // Equality tests only, so x1/y1 at the screen edge never overflow.
  // A step on the last pixel is suppressed so counters never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx0 <= '0;
      rx1 <= '0;
      ry1 <= '0;
      cx  <= '0;
      cy  <= '0;
    end else if (load) begin
      rx0 <= x0;
      rx1 <= x1;
      ry1 <= y1;
      cx  <= x0;
      cy  <= y0;
    end else if (step && !last) begin
      if (cx == rx1) begin
        cx <= rx0;
        cy <= cy + COORD_W'(1);
      end else begin
        cx <= cx + COORD_W'(1);
      end
    end
  end
endmodule

// File: rtl/vram_write_ctrl.sv
// Shares the VRAM write port between a host pixel stream and a fill engine.
// Ports: i_Clk, i_Reset, host (slave), fill_* controls/status, vram_we/addr/din.
module vram_write_ctrl
  import vram_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset,
  vram_write_ctrl_if.slave   host,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_x1,
  input  logic [COORD_W-1:0] fill_y1,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [COLOR_W-1:0] vram_din
);
  state_t state, state_n;
  turn_t  turn, turn_n;

  logic [COLOR_W-1:0] color_q;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               last;
  logic               sel_host, sel_fill;
  logic               load, done_n, degen;

  assign host.req_ready = (state == ST_IDLE) ||
                          (state == ST_FILL && turn == TURN_HOST);
  assign fill_busy = (state == ST_FILL);
  assign degen = (fill_x1 < fill_x0) || (fill_y1 < fill_y0);

  vram_fill_walker u_walker (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .load  (load),
    .step  (sel_fill),
    .x0    (fill_x0),
    .y0    (fill_y0),
    .x1    (fill_x1),
    .y1    (fill_y1),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .last  (last)
  );

  always_comb begin
    state_n  = state;
    turn_n   = turn;
    sel_host = 1'b0;
    sel_fill = 1'b0;
    load     = 1'b0;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        sel_host = host.req_valid;
        if (fill_start) begin
          load   = 1'b1;
          turn_n = TURN_FILL;
          if (degen) done_n  = 1'b1;
          else       state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        if (turn == TURN_HOST && host.req_valid) begin
          sel_host = 1'b1;
          turn_n   = TURN_FILL;
        end else begin
          // Fill takes the slot; an idle host turn is not wasted.
          sel_fill = 1'b1;
          if (turn == TURN_FILL) turn_n = TURN_HOST;
          if (last) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= ST_IDLE;
      turn      <= TURN_FILL;
      color_q   <= '0;
      fill_done <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      state     <= state_n;
      turn      <= turn_n;
      fill_done <= done_n;
      vram_we   <= sel_host || sel_fill;
      if (load) color_q <= fill_color;
      if (sel_host) begin
        vram_addr <= pack_addr(host.req_y, host.req_x);
        vram_din  <= host.req_color;
      end else if (sel_fill) begin
        vram_addr <= pack_addr(cur_y, cur_x);
        vram_din  <= color_q;
      end
    end
  end
endmodule
